// File: rtl/axi_stream_video_pkg.sv
// Shared types and constants for the AXI4-Stream video checker and its ready generator.
package axi_stream_video_pkg;

  localparam int VID_DIM_W = 11;

  // Fibonacci taps 16,14,13,11 as a mask over the 16-bit LFSR state.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_SOF = 2'd1,
    IN_FRAME = 2'd2
  } chk_state_t;

  typedef enum logic [1:0] {
    RDY_ALWAYS = 2'd0,
    RDY_ALT    = 2'd1,
    RDY_LFSR   = 2'd2,
    RDY_NEVER  = 2'd3
  } ready_mode_t;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/axi_stream_ready_gen.sv
// Registered TREADY pattern generator: always, alternating, LFSR-driven or never ready.
module axi_stream_ready_gen
  import axi_stream_video_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        active,
  input  ready_mode_t mode,
  output logic        tready
);

  logic [15:0] lfsr;

  // The LFSR free-runs so the pattern does not depend on when the checker was enabled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr   <= LFSR_SEED;
      tready <= 1'b0;
    end else begin
      lfsr <= lfsr_step(lfsr);
      if (!active) begin
        tready <= 1'b0;
      end else begin
        case (mode)
          RDY_ALWAYS: tready <= 1'b1;
          RDY_ALT:    tready <= ~tready;
          RDY_LFSR:   tready <= lfsr[0];
          default:    tready <= 1'b0;
        endcase
      end
    end
  end

endmodule

// File: rtl/axi_stream_tp_check.sv
// AXI4-Stream video sink: drives back-pressure, checks SOF/EOL/geometry, counts good frames.
// Defining AXI_STREAM_TP_CHECK_DATA_EN adds the TDATA pattern check and err_data_o.
module axi_stream_tp_check
  import axi_stream_video_pkg::*;
#(
  parameter int          TDATA_W   = 32,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic [TDATA_W-1:0]   tdata,
  input  logic                 tvalid,
  input  logic                 tuser,
  input  logic                 tlast,
  output logic                 tready,
  input  logic                 chk_enable_i,
  input  logic [VID_DIM_W-1:0] chk_width_i,
  input  logic [VID_DIM_W-1:0] chk_height_i,
  input  logic [1:0]           ready_mode_i,
  input  logic                 clear_i,
  output logic [15:0]          frame_cnt_o,
  output logic [VID_DIM_W-1:0] meas_width_o,
  output logic [VID_DIM_W-1:0] meas_height_o,
  output logic                 err_short_o,
  output logic                 err_long_o,
  output logic                 err_sof_o,
`ifdef AXI_STREAM_TP_CHECK_DATA_EN
  output logic                 err_data_o,
`endif
  output logic                 locked_o
);

  chk_state_t           state, state_nxt;
  ready_mode_t          mode_q;
  logic [2:0]           en_sync;
  logic                 en_rise, en_fall, active;
  logic [VID_DIM_W-1:0] width_q, height_q, px, ln;
  logic [VID_DIM_W-1:0] px_cur, ln_cur, px_inc;
  logic                 frame_bad, from_frame, bad_cur;
  logic                 acc, in_frame_beat, short_ev, long_ev, sof_ev, data_ev;
  logic                 frame_end, frame_ok;

  always_ff @(posedge aclk) begin
    if (!aresetn) en_sync <= '0;
    else          en_sync <= {en_sync[1:0], chk_enable_i};
  end
  assign en_rise = en_sync[1] & ~en_sync[2];
  assign en_fall = ~en_sync[1] & en_sync[2];

  axi_stream_ready_gen #(.LFSR_SEED(LFSR_SEED)) u_ready (
    .clk    (aclk),
    .rst_n  (aresetn),
    .active (active),
    .mode   (mode_q),
    .tready (tready)
  );

  // A SOF beat is pixel 0 of line 0 of a fresh frame, whatever state it arrives in.
  assign acc           = tvalid & tready;
  assign in_frame_beat = acc && (state == IN_FRAME || (state == WAIT_SOF && tuser));
  assign px_cur        = tuser ? '0 : px;
  assign ln_cur        = tuser ? '0 : ln;
  assign bad_cur       = tuser ? 1'b0 : frame_bad;
  assign px_inc        = px_cur + 11'd1;
  assign short_ev      = in_frame_beat && tlast && (px_inc < width_q);
  assign long_ev       = in_frame_beat && !tlast && (px_inc == width_q);
  assign sof_ev        = acc && ((state == IN_FRAME && tuser) ||
                                 (state == WAIT_SOF && !tuser && from_frame));
  assign frame_end     = in_frame_beat && tlast && (ln_cur == height_q - 11'd1);
  assign frame_ok      = frame_end && !(bad_cur | short_ev | long_ev | data_ev);

  always_ff @(posedge aclk) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (en_fall)      state_nxt = IDLE;
    else if (en_rise) state_nxt = WAIT_SOF;
    else begin
      case (state)
        WAIT_SOF: if (acc && tuser) state_nxt = frame_end ? WAIT_SOF : IN_FRAME;
        IN_FRAME: if (frame_end)    state_nxt = WAIT_SOF;
        default:  state_nxt = state;
      endcase
    end
  end

  always_comb begin
    locked_o = (state == IN_FRAME);
    active   = (state != IDLE);
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      mode_q <= RDY_ALWAYS;
      {width_q, height_q, px, ln} <= '0;
      {frame_bad, from_frame} <= '0;
      {err_short_o, err_long_o, err_sof_o} <= '0;
      frame_cnt_o   <= '0;
      meas_width_o  <= '0;
      meas_height_o <= '0;
    end else if (en_rise) begin
      mode_q   <= ready_mode_t'(ready_mode_i);
      width_q  <= chk_width_i;
      height_q <= chk_height_i;
      {px, ln} <= '0;
      {frame_bad, from_frame} <= '0;
      {err_short_o, err_long_o, err_sof_o} <= '0;
      frame_cnt_o   <= '0;
      meas_width_o  <= '0;
      meas_height_o <= '0;
    end else if (!en_fall) begin
      if (clear_i) begin
        {err_short_o, err_long_o, err_sof_o} <= '0;
        frame_cnt_o   <= '0;
        meas_width_o  <= '0;
        meas_height_o <= '0;
      end
      if (short_ev) err_short_o <= 1'b1;
      if (long_ev)  err_long_o  <= 1'b1;
      if (sof_ev)   err_sof_o   <= 1'b1;
      if (acc && state == WAIT_SOF) from_frame <= 1'b0;
      if (in_frame_beat) begin
        frame_bad <= bad_cur | short_ev | long_ev | data_ev;
        if (tlast) begin
          meas_width_o <= px_inc;
          px <= '0;
          ln <= ln_cur + 11'd1;
        end else begin
          px <= (px_cur == 11'h7FF) ? px_cur : px_inc;
          ln <= ln_cur;
        end
        if (frame_end) begin
          meas_height_o <= height_q;
          from_frame    <= 1'b1;
        end
        if (frame_ok) frame_cnt_o <= (clear_i ? 16'd0 : frame_cnt_o) + 16'd1;
      end
    end
  end

`ifdef AXI_STREAM_TP_CHECK_DATA_EN
  logic [7:0] frame_tag;
  logic       unused_tdata;
  assign unused_tdata = ^tdata[TDATA_W-1:24];
  assign data_ev = in_frame_beat && (tdata[7:0] != ln_cur[7:0] || tdata[15:8] != px_cur[7:0] ||
                                     (!tuser && tdata[23:16] != frame_tag));

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      frame_tag  <= '0;
      err_data_o <= 1'b0;
    end else if (en_rise) begin
      err_data_o <= 1'b0;
    end else if (!en_fall) begin
      if (clear_i) err_data_o <= 1'b0;
      if (data_ev) err_data_o <= 1'b1;
      if (in_frame_beat && tuser) frame_tag <= tdata[23:16];
    end
  end
`else
  logic unused_tdata;
  assign unused_tdata = ^tdata;
  assign data_ev      = 1'b0;
`endif

endmodule

// File: tb/tb_axi_stream_tp_check.sv
// Self-checking bench for axi_stream_tp_check using a frame-level reference model.
module tb_axi_stream_tp_check;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [31:0] tdata = '0;
  logic        tvalid = 1'b0, tuser = 1'b0, tlast = 1'b0, tready;
  logic        chk_enable_i = 1'b0, clear_i = 1'b0;
  logic [10:0] chk_width_i = '0, chk_height_i = '0;
  logic [1:0]  ready_mode_i = '0;
  logic [15:0] frame_cnt_o;
  logic [10:0] meas_width_o, meas_height_o;
  logic        err_short_o, err_long_o, err_sof_o, locked_o;
`ifdef AXI_STREAM_TP_CHECK_DATA_EN
  logic        err_data_o;
`endif

  int checks = 0, passes = 0;
  int rdy_hi = 0, rdy_lo = 0;
  bit stalled = 0;
  int lens_q[$];

  always #5 aclk = ~aclk;

  axi_stream_tp_check dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .tdata         (tdata),
    .tvalid        (tvalid),
    .tuser         (tuser),
    .tlast         (tlast),
    .tready        (tready),
    .chk_enable_i  (chk_enable_i),
    .chk_width_i   (chk_width_i),
    .chk_height_i  (chk_height_i),
    .ready_mode_i  (ready_mode_i),
    .clear_i       (clear_i),
    .frame_cnt_o   (frame_cnt_o),
    .meas_width_o  (meas_width_o),
    .meas_height_o (meas_height_o),
    .err_short_o   (err_short_o),
    .err_long_o    (err_long_o),
    .err_sof_o     (err_sof_o),
`ifdef AXI_STREAM_TP_CHECK_DATA_EN
    .err_data_o    (err_data_o),
`endif
    .locked_o      (locked_o)
  );

  // Holds the beat until the sink accepts it; a stuck TREADY is reported once and later beats are skipped.
  task automatic send_beat(input logic u, input logic l, input logic [31:0] d);
    int n;
    n = 0;
    if (stalled) return;
    tvalid = 1'b1; tuser = u; tlast = l; tdata = d;
    forever begin
      @(negedge aclk);
      if (tready === 1'b1) begin rdy_hi++; break; end
      rdy_lo++;
      n++;
      if (n >= 300) break;
    end
    if (n >= 300) begin
      checks++;
      stalled = 1;
      $display("FAIL beat_timeout tready got 0 for 300 cycles, required 1");
    end else begin
      @(posedge aclk);
    end
    #1;
    tvalid = 1'b0; tuser = 1'b0; tlast = 1'b0;
  endtask

  // Sends lens_q.size() lines of the given lengths using the generator pattern.
  task automatic send_frame(input bit with_sof, input int bad_beat);
    logic [7:0] fc;
    int k;
    fc = 8'($urandom);
    k = 0;
    for (int l = 0; l < lens_q.size(); l++) begin
      for (int p = 0; p < lens_q[l]; p++) begin
        logic [31:0] d;
        d = {8'($urandom), fc, 8'(p), 8'(l)};
        if (k == bad_beat) d[15:8] = ~d[15:8];
        send_beat(with_sof && l == 0 && p == 0, p == lens_q[l] - 1, d);
        k++;
      end
    end
  endtask

  // Frame-level reference: a frame is good only if every line has exactly the configured length.
  task automatic model_frame(input int w, output bit good, output bit sh, output bit lg, output int lastlen);
    sh = 0; lg = 0;
    foreach (lens_q[i]) begin
      if (lens_q[i] < w) sh = 1;
      if (lens_q[i] > w) lg = 1;
    end
    good = !sh && !lg;
    lastlen = lens_q[lens_q.size() - 1];
  endtask

  task automatic configure(input int w, input int h, input int m);
    chk_enable_i = 1'b0;
    repeat (6) @(posedge aclk);
    #1;
    chk_width_i = 11'(w); chk_height_i = 11'(h); ready_mode_i = 2'(m);
    chk_enable_i = 1'b1;
    repeat (6) @(posedge aclk);
    #1;
  endtask

  task automatic pulse_clear();
    clear_i = 1'b1;
    @(posedge aclk);
    #1;
    clear_i = 1'b0;
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    checks++; if (frame_cnt_o !== 16'd0) $display("FAIL reset_frame_cnt got %0d required 0", frame_cnt_o); else passes++;
    checks++; if (meas_width_o !== 11'd0) $display("FAIL reset_meas_width got %0d required 0", meas_width_o); else passes++;
    checks++; if (meas_height_o !== 11'd0) $display("FAIL reset_meas_height got %0d required 0", meas_height_o); else passes++;
    checks++; if ({err_short_o, err_long_o, err_sof_o} !== 3'b000) $display("FAIL reset_errs got %b required 000", {err_short_o, err_long_o, err_sof_o}); else passes++;
    checks++; if (locked_o !== 1'b0) $display("FAIL reset_locked got %b required 0", locked_o); else passes++;
    checks++; if (tready !== 1'b0) $display("FAIL reset_tready got %b required 0", tready); else passes++;
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    repeat (5) @(negedge aclk);
    checks++; if (tready !== 1'b0) $display("FAIL idle_tready got %b required 0", tready); else passes++;
  endtask

  task automatic test_clean();
    configure(8, 4, 0);
    lens_q = '{8, 8, 8, 8};
    repeat (3) send_frame(1, -1);
    checks++; if (frame_cnt_o !== 16'd3) $display("FAIL clean_frame_cnt got %0d required 3", frame_cnt_o); else passes++;
    checks++; if (meas_width_o !== 11'd8) $display("FAIL clean_meas_width got %0d required 8", meas_width_o); else passes++;
    checks++; if (meas_height_o !== 11'd4) $display("FAIL clean_meas_height got %0d required 4", meas_height_o); else passes++;
    checks++; if ({err_short_o, err_long_o, err_sof_o} !== 3'b000) $display("FAIL clean_errs got %b required 000", {err_short_o, err_long_o, err_sof_o}); else passes++;
    checks++; if (locked_o !== 1'b0) $display("FAIL clean_locked_after got %b required 0", locked_o); else passes++;
`ifdef AXI_STREAM_TP_CHECK_DATA_EN
    checks++; if (err_data_o !== 1'b0) $display("FAIL clean_err_data got %b required 0", err_data_o); else passes++;
`endif
  endtask

  task automatic test_lfsr();
    configure(640, 2, 2);
    lens_q = '{640, 640};
    rdy_hi = 0; rdy_lo = 0;
    send_frame(1, -1);
    checks++; if (frame_cnt_o !== 16'd1) $display("FAIL lfsr_frame1_cnt got %0d required 1", frame_cnt_o); else passes++;
    send_frame(1, -1);
    checks++; if (frame_cnt_o !== 16'd2) $display("FAIL lfsr_frame2_cnt got %0d required 2", frame_cnt_o); else passes++;
    checks++; if (meas_width_o !== 11'd640) $display("FAIL lfsr_meas_width got %0d required 640", meas_width_o); else passes++;
    checks++; if (meas_height_o !== 11'd2) $display("FAIL lfsr_meas_height got %0d required 2", meas_height_o); else passes++;
    checks++; if ({err_short_o, err_long_o, err_sof_o} !== 3'b000) $display("FAIL lfsr_errs got %b required 000", {err_short_o, err_long_o, err_sof_o}); else passes++;
    checks++; if (rdy_hi == 0 || rdy_lo == 0) $display("FAIL lfsr_tready_mix got hi=%0d lo=%0d required both nonzero", rdy_hi, rdy_lo); else passes++;
  endtask

  task automatic test_random();
    int w, h, exp_cnt, exp_mw;
    bit exp_sh, exp_lg, good, sh, lg;
    int lastlen;
    w = $urandom_range(2, 12);
    h = $urandom_range(1, 5);
    configure(w, h, 1);
    exp_cnt = 0; exp_sh = 0; exp_lg = 0; exp_mw = 0;
    for (int f = 0; f < 6; f++) begin
      int r;
      lens_q.delete();
      for (int l = 0; l < h; l++) lens_q.push_back(w);
      r = $urandom_range(0, 5);
      if (r < 2) lens_q[$urandom_range(0, h - 1)] = $urandom_range(1, w - 1);
      else if (r == 2) lens_q[$urandom_range(0, h - 1)] = w + $urandom_range(1, 3);
      model_frame(w, good, sh, lg, lastlen);
      exp_cnt += int'(good);
      exp_sh |= sh; exp_lg |= lg; exp_mw = lastlen;
      send_frame(1, -1);
      checks++; if (frame_cnt_o !== 16'(exp_cnt)) $display("FAIL rand_frame_cnt f%0d got %0d required %0d", f, frame_cnt_o, exp_cnt); else passes++;
      checks++; if (meas_width_o !== 11'(exp_mw)) $display("FAIL rand_meas_width f%0d got %0d required %0d", f, meas_width_o, exp_mw); else passes++;
      checks++; if (err_short_o !== exp_sh) $display("FAIL rand_err_short f%0d got %b required %b", f, err_short_o, exp_sh); else passes++;
      checks++; if (err_long_o !== exp_lg) $display("FAIL rand_err_long f%0d got %b required %b", f, err_long_o, exp_lg); else passes++;
    end
    checks++; if (meas_height_o !== 11'(h)) $display("FAIL rand_meas_height got %0d required %0d", meas_height_o, h); else passes++;
  endtask

  task automatic test_short();
    configure(8, 4, 0);
    lens_q = '{8, 8, 8, 6};
    send_frame(1, -1);
    checks++; if (err_short_o !== 1'b1) $display("FAIL short_err got %b required 1", err_short_o); else passes++;
    checks++; if (meas_width_o !== 11'd6) $display("FAIL short_meas_width got %0d required 6", meas_width_o); else passes++;
    checks++; if (frame_cnt_o !== 16'd0) $display("FAIL short_frame_cnt got %0d required 0", frame_cnt_o); else passes++;
    checks++; if (err_long_o !== 1'b0) $display("FAIL short_err_long got %b required 0", err_long_o); else passes++;
    lens_q = '{8, 8, 8, 8};
    send_frame(1, -1);
    checks++; if (frame_cnt_o !== 16'd1 || err_short_o !== 1'b1) $display("FAIL short_then_clean got cnt=%0d short=%b required cnt=1 short=1", frame_cnt_o, err_short_o); else passes++;
    pulse_clear();
    checks++; if ({frame_cnt_o, meas_width_o, meas_height_o, err_short_o} !== 39'd0) $display("FAIL clear_all got cnt=%0d mw=%0d mh=%0d short=%b required zeros", frame_cnt_o, meas_width_o, meas_height_o, err_short_o); else passes++;
  endtask

  task automatic test_sof();
    configure(4, 4, 0);
    for (int l = 0; l < 3; l++)
      for (int p = 0; p < ((l == 2) ? 3 : 4); p++)
        send_beat(l == 0 && p == 0, l < 2 && p == 3, {8'h00, 8'h5A, 8'(p), 8'(l)});
    checks++; if (err_sof_o !== 1'b0 || locked_o !== 1'b1) $display("FAIL sof_before got sof=%b locked=%b required sof=0 locked=1", err_sof_o, locked_o); else passes++;
    lens_q = '{4, 4, 4, 4};
    send_frame(1, -1);
    checks++; if (err_sof_o !== 1'b1) $display("FAIL sof_err got %b required 1", err_sof_o); else passes++;
    checks++; if (frame_cnt_o !== 16'd1) $display("FAIL sof_restart_cnt got %0d required 1", frame_cnt_o); else passes++;
    checks++; if ({err_short_o, err_long_o} !== 2'b00) $display("FAIL sof_other_errs got %b required 00", {err_short_o, err_long_o}); else passes++;
    pulse_clear();
    checks++; if (err_sof_o !== 1'b0) $display("FAIL sof_clear got %b required 0", err_sof_o); else passes++;
    send_beat(1'b0, 1'b0, 32'h0);
    checks++; if (err_sof_o !== 1'b1 || locked_o !== 1'b0) $display("FAIL sof_missing got sof=%b locked=%b required sof=1 locked=0", err_sof_o, locked_o); else passes++;
  endtask

  task automatic test_disable();
    configure(8, 4, 0);
    lens_q = '{6, 8};
    send_frame(1, -1);
    checks++; if (err_short_o !== 1'b1 || locked_o !== 1'b1) $display("FAIL dis_pre got short=%b locked=%b required 1 1", err_short_o, locked_o); else passes++;
    chk_enable_i = 1'b0;
    repeat (10) @(posedge aclk);
    @(negedge aclk);
    checks++; if (tready !== 1'b0 || locked_o !== 1'b0) $display("FAIL dis_idle got tready=%b locked=%b required 0 0", tready, locked_o); else passes++;
    checks++; if (err_short_o !== 1'b1) $display("FAIL dis_hold got short=%b required 1", err_short_o); else passes++;
    #1;
    chk_enable_i = 1'b1;
    repeat (6) @(posedge aclk);
    #1;
    checks++; if (err_short_o !== 1'b0 || frame_cnt_o !== 16'd0) $display("FAIL reen_clear got short=%b cnt=%0d required 0 0", err_short_o, frame_cnt_o); else passes++;
    lens_q = '{8, 8, 8, 8};
    send_frame(0, -1);
    checks++; if (frame_cnt_o !== 16'd0 || locked_o !== 1'b0 || err_sof_o !== 1'b0) $display("FAIL reen_discard got cnt=%0d locked=%b sof=%b required 0 0 0", frame_cnt_o, locked_o, err_sof_o); else passes++;
    send_frame(1, -1);
    checks++; if (frame_cnt_o !== 16'd1 || {err_short_o, err_long_o, err_sof_o} !== 3'b000) $display("FAIL reen_clean got cnt=%0d errs=%b required 1 000", frame_cnt_o, {err_short_o, err_long_o, err_sof_o}); else passes++;
  endtask

  task automatic test_ready_modes();
    int hi, toggles;
    logic prev;
    configure(8, 4, 3);
    hi = 0;
    repeat (20) begin @(negedge aclk); if (tready !== 1'b0) hi++; end
    checks++; if (hi != 0) $display("FAIL never_ready got %0d high cycles required 0", hi); else passes++;
    configure(8, 4, 1);
    @(negedge aclk);
    prev = tready;
    toggles = 0;
    repeat (8) begin @(negedge aclk); if (tready !== prev) toggles++; prev = tready; end
    checks++; if (toggles != 8) $display("FAIL alt_ready got %0d toggles required 8", toggles); else passes++;
  endtask

`ifdef AXI_STREAM_TP_CHECK_DATA_EN
  task automatic test_data();
    configure(8, 2, 0);
    lens_q = '{8, 8};
    send_frame(1, 5);
    checks++; if (err_data_o !== 1'b1) $display("FAIL data_err got %b required 1", err_data_o); else passes++;
    checks++; if ({err_short_o, err_long_o, err_sof_o} !== 3'b000) $display("FAIL data_other_errs got %b required 000", {err_short_o, err_long_o, err_sof_o}); else passes++;
    checks++; if (frame_cnt_o !== 16'd0) $display("FAIL data_frame_cnt got %0d required 0", frame_cnt_o); else passes++;
    send_frame(1, -1);
    checks++; if (frame_cnt_o !== 16'd1 || err_data_o !== 1'b1) $display("FAIL data_clean got cnt=%0d data=%b required 1 1", frame_cnt_o, err_data_o); else passes++;
  endtask
`endif

  initial begin
    test_reset();
    test_clean();
    test_lfsr();
    test_random();
    test_short();
    test_sof();
    test_disable();
    test_ready_modes();
`ifdef AXI_STREAM_TP_CHECK_DATA_EN
    test_data();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/axi_stream_tp_check.md
Name: axi_stream_tp_check

Overview:
AXI4-Stream video sink and checker. It is the receiving end for the test-pattern generator's stream.
- Accepts beats and drives TREADY with a selectable back-pressure pattern.
- Checks frame structure: SOF on TUSER[0], EOL on TLAST, configured width and height.
- Counts good frames and reports sticky error flags and measured line and frame geometry to registers.
- Sits between the video pipeline under test and the AXI-Lite register block.

Parameters:
- TDATA_W, 32, stream data width in bits; must be ≥32.
- LFSR_SEED, 16'hACE1, reset seed of the back-pressure LFSR.

Ports:
- axi_stream_i.ACLK  input  1  clock, taken from interface.
- axi_stream_i.ARESETn  input  1  reset, taken from interface.
- axi_stream_i  axi4_stream_if.m  -  sink side; uses TDATA, TVALID, TUSER[0], TLAST; drives TREADY; TKEEP ignored.
- chk_enable_i  input  1  enable, asynchronous to the stream, level.
- chk_width_i  input  11  expected pixels per line, 1..2047.
- chk_height_i  input  11  expected lines per frame, 1..2047.
- ready_mode_i  input  2  0 = always ready, 1 = ready every other cycle, 2 = LFSR bit 0, 3 = never ready.
- clear_i  input  1  single-cycle pulse; clears sticky errors and counters.
- frame_cnt_o  output  16  complete good frames received.
- meas_width_o  output  11  beats in the last completed line.
- meas_height_o  output  11  lines in the last completed frame.
- err_short_o  output  1  sticky; TLAST before the width was reached.
- err_long_o  output  1  sticky; no TLAST at beat width-1.
- err_sof_o  output  1  sticky; SOF mid-frame, or first beat of a frame without SOF.
- locked_o  output  1  currently inside a frame that started with a valid SOF.

Behaviour:
- Clock and reset: single clock ACLK. ARESETn is synchronous, active-low, and takes priority over everything.
- Reset values: all outputs 0; TREADY 0; state IDLE; LFSR = LFSR_SEED.
- Transfer rule: a beat counts only when TVALID && TREADY are both high in the same cycle. No other input is sampled.
- Enable synchronisation: chk_enable_i passes through a 3-flop synchroniser.
  - Rising edge: latch width, height and mode; clear counters and errors; go to WAIT_SOF.
  - Falling edge: go to IDLE from any state.
- TREADY generation:
  - Registered; all modes except 3 are active only outside IDLE.
  - Mode 1 toggles every cycle, starting at 1.
  - Mode 2: 16-bit Fibonacci LFSR (taps 16,14,13,11), advancing every cycle; TREADY = bit 0.
  - TREADY never depends on TVALID.
- State IDLE: TREADY = 0; counters hold.
- State WAIT_SOF: beats with TUSER = 0 are discarded. A beat with TUSER = 1 loads px = 1, ln = 0 and moves to IN_FRAME.
  - Exception: if WAIT_SOF was entered from a completed frame, the first discarded beat sets err_sof_o.
- State IN_FRAME, on each accepted beat:
  - TUSER = 1: set err_sof_o; restart the frame (px = 1, ln = 0). frame_cnt_o is not incremented.
  - TLAST with px+1 < width: set err_short_o.
  - px+1 == width without TLAST: set err_long_o; keep counting. px saturates at 2047.
  - On TLAST: meas_width_o <= px+1; px <= 0; ln <= ln+1.
  - TLAST on line height-1: meas_height_o <= height; state goes to WAIT_SOF. frame_cnt_o increments only if no error occurred within that frame (per-frame error flag).
  - Simultaneous SOF and TLAST on the same beat: SOF restart takes priority, and the one-beat line is measured.
- Arithmetic and widths: frame_cnt_o wraps 0xFFFF -> 0. Width and height comparisons are 11-bit unsigned, with no carry beyond 11 bits.
- locked_o = (state == IN_FRAME).
- clear_i: in the same cycle, clears errors, frame_cnt_o and the measured values; state is unaffected. If clear_i coincides with an error event, the error wins (it is set).
- Output latency: all outputs are registered; each updates on the clock edge after the accepted beat.

Optional Feature:
AXI_STREAM_TP_CHECK_DATA_EN
- Defined: adds output err_data_o (sticky) and checks each accepted beat against the generator pattern:
  - TDATA[7:0] == ln[7:0]
  - TDATA[15:8] == px[7:0]
  - TDATA[23:16] == constant per frame, sampled at SOF
  - TDATA[31:24] is not checked.
- A mismatch sets err_data_o and marks the frame bad.
- Not defined: no data checking; the port is absent; TDATA is unused.

Decomposition:
- Package axi_stream_video_pkg holds:
  - enum chk_state_t {IDLE, WAIT_SOF, IN_FRAME}
  - enum ready_mode_t
  - constant VID_DIM_W = 11
  - LFSR tap constant.
- One natural sub-module: axi_stream_ready_gen, which produces TREADY from the mode and the LFSR. The checker FSM stays in the top module.

Test Plan:
- Width 8, height 4, mode 0, three clean frames -> frame_cnt_o = 3, meas_width_o = 8, meas_height_o = 4, no errors.
- Mode 2, width 640, height 2 -> TREADY toggles pseudo-randomly, frame_cnt_o increments once per frame, no errors, no beat lost or duplicated.
- Width 8, TLAST on beat 6 -> err_short_o = 1, meas_width_o = 6, frame_cnt_o unchanged for that frame.
- SOF on line 2 pixel 3 of a 4x4 frame -> err_sof_o = 1; the frame restarts; the next clean frame gives frame_cnt_o = 1.
- Disable mid-frame for 10 cycles, then re-enable -> TREADY = 0 while idle; errors and counters are cleared on re-enable; the first frame without SOF is discarded.
- With AXI_STREAM_TP_CHECK_DATA_EN, corrupt TDATA[15:8] on one beat -> err_data_o = 1; the other flags stay 0.
